// File: rtl/program_loader_pkg.sv
// Shared encodings for the program loader: host command bytes, reply bytes and FSM states.
package program_loader_pkg;

    typedef enum logic [3:0] {
        IDLE, ADDR_H, ADDR_L, LEN, WDATA, RISSUE, RWAIT1, RWAIT2, RSEND, GO1, GO2, REPLY
    } state_t;

    localparam logic [7:0] CMD_WRITE  = 8'h57;
    localparam logic [7:0] CMD_READ   = 8'h52;
    localparam logic [7:0] CMD_GO     = 8'h47;
    localparam logic [7:0] CMD_HALT   = 8'h48;
    localparam logic [7:0] CMD_STATUS = 8'h53;
    localparam logic [7:0] BYTE_ACK   = 8'h06;
    localparam logic [7:0] BYTE_NAK   = 8'h15;

endpackage

// File: rtl/program_loader.sv
// Host-command program loader: decodes a UART byte stream, reads/writes program RAM while it owns
// the memory port, and controls the core's reset, halt and start address.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 9,
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  cpu_reset,
    output logic                  cpu_halt,
    input  logic                  cpu_halted,
    output logic [ADDR_WIDTH-1:0] start_address,
    input  logic [ADDR_WIDTH-1:0] cpu_raddr,
    input  logic [ADDR_WIDTH-1:0] cpu_waddr,
    input  logic [7:0]            cpu_wdata,
    input  logic                  cpu_write,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_write,
    input  logic [7:0]            mem_rdata,
    output state_t                fsm_state
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                state, state_next;
    logic [7:0]            cmd, addr_hi;
    logic [ADDR_WIDTH-1:0] addr, lw_addr;
    logic [7:0]            lw_data;
    logic                  lw_write;
    logic [8:0]            count;
    logic                  frame_ok;
    logic [TO_W-1:0]       to_cnt;
    logic                  own, waiting, timeout, tx_done, tx_load;
    logic [7:0]            tx_byte;

    // tx handshake: a byte transfers on any cycle with tx_valid & tx_ready; tx_valid and tx_data
    // hold their values until that happens. rx bytes are 1-cycle strobes with no backpressure.
    assign own     = cpu_reset | cpu_halted;
    assign waiting = state inside {ADDR_H, ADDR_L, LEN, WDATA};
    assign timeout = waiting && !rx_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign tx_done = tx_valid & tx_ready;

    assign mem_raddr = own ? addr     : cpu_raddr;
    assign mem_waddr = own ? lw_addr  : cpu_waddr;
    assign mem_wdata = own ? lw_data  : cpu_wdata;
    assign mem_write = own ? lw_write : cpu_write;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        tx_load    = 1'b0;
        tx_byte    = BYTE_ACK;
        if (timeout) begin
            state_next = REPLY;
            tx_load    = 1'b1;
            tx_byte    = BYTE_NAK;
        end else begin
            case (state)
                IDLE: if (rx_valid) begin
                    case (rx_data)
                        CMD_WRITE, CMD_READ, CMD_GO: state_next = ADDR_H;
                        CMD_HALT: begin
                            state_next = REPLY;
                            tx_load    = 1'b1;
                        end
                        CMD_STATUS: begin
                            state_next = REPLY;
                            tx_load    = 1'b1;
                            tx_byte    = {6'b0, cpu_reset, cpu_halted};
                        end
                        default: begin
                            state_next = REPLY;
                            tx_load    = 1'b1;
                            tx_byte    = BYTE_NAK;
                        end
                    endcase
                end
                ADDR_H: if (rx_valid) state_next = ADDR_L;
                ADDR_L: if (rx_valid) state_next = (cmd == CMD_GO) ? GO1 : LEN;
                LEN: if (rx_valid) begin
                    if (cmd == CMD_WRITE)  state_next = WDATA;
                    else if (frame_ok)     state_next = RISSUE;
                    else begin
                        state_next = REPLY;
                        tx_load    = 1'b1;
                        tx_byte    = BYTE_NAK;
                    end
                end
                WDATA: if (rx_valid && count == 9'd1) begin
                    state_next = REPLY;
                    tx_load    = 1'b1;
                    tx_byte    = frame_ok ? BYTE_ACK : BYTE_NAK;
                end
                RISSUE: state_next = RWAIT1;
                RWAIT1: state_next = RWAIT2;
                RWAIT2: begin
                    state_next = RSEND;
                    tx_load    = 1'b1;
                    tx_byte    = mem_rdata;
                end
                RSEND: if (tx_done) begin
                    if (count == 9'd1) begin
                        state_next = REPLY;
                        tx_load    = 1'b1;
                    end else begin
                        state_next = RISSUE;
                    end
                end
                GO1: state_next = GO2;
                GO2: begin
                    state_next = REPLY;
                    tx_load    = 1'b1;
                end
                REPLY: if (tx_done) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_reset     <= 1'b1;
            cpu_halt      <= 1'b0;
            start_address <= '0;
            tx_valid      <= 1'b0;
            tx_data       <= 8'h00;
            lw_write      <= 1'b0;
            lw_addr       <= '0;
            lw_data       <= 8'h00;
            addr          <= '0;
            addr_hi       <= 8'h00;
            cmd           <= 8'h00;
            count         <= 9'd0;
            frame_ok      <= 1'b0;
            to_cnt        <= '0;
        end else begin
            lw_write <= 1'b0;
            if (tx_load) begin
                tx_valid <= 1'b1;
                tx_data  <= tx_byte;
            end else if (tx_done) begin
                tx_valid <= 1'b0;
            end
            to_cnt <= (waiting && !rx_valid) ? to_cnt + 1'b1 : '0;
            case (state)
                IDLE: if (rx_valid) begin
                    cmd      <= rx_data;
                    frame_ok <= own;
                    if (rx_data == CMD_HALT) cpu_halt <= 1'b1;
                end
                ADDR_H: if (rx_valid) addr_hi <= rx_data;
                ADDR_L: if (rx_valid) begin
                    addr <= ADDR_WIDTH'({addr_hi, rx_data});
                    if (cmd == CMD_GO) begin
                        start_address <= ADDR_WIDTH'({addr_hi, rx_data});
                        cpu_reset     <= 1'b1;
                        cpu_halt      <= 1'b0;
                    end
                end
                LEN: if (rx_valid) count <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                // The write strobe lands the cycle after its data byte, using the pre-increment address.
                WDATA: if (rx_valid) begin
                    lw_write <= frame_ok;
                    lw_addr  <= addr;
                    lw_data  <= rx_data;
                    addr     <= addr + 1'b1;
                    count    <= count - 1'b1;
                end
                RSEND: if (tx_done) begin
                    addr  <= addr + 1'b1;
                    count <= count - 1'b1;
                end
                GO2: cpu_reset <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: RAM and core models, tx/write monitors, immediate-assertion checks.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int AW = 9;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          cpu_reset, cpu_halt, cpu_halted;
    logic [AW-1:0] start_address;
    logic [AW-1:0] cpu_raddr, cpu_waddr, mem_raddr, mem_waddr;
    logic [7:0]    cpu_wdata, mem_wdata, mem_rdata;
    logic          cpu_write, mem_write;
    state_t        fsm_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run = 0;
    int max_run = 0;
    int go_hi = 0;
    logic [7:0]  tx_q[$];
    logic [16:0] wr_q[$];
    logic [7:0]  ram[0:511];
    logic [7:0]  rd1, rd2;

    always #5 clk = ~clk;

    program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cpu_reset(cpu_reset), .cpu_halt(cpu_halt), .cpu_halted(cpu_halted),
        .start_address(start_address), .cpu_raddr(cpu_raddr), .cpu_waddr(cpu_waddr),
        .cpu_wdata(cpu_wdata), .cpu_write(cpu_write), .mem_raddr(mem_raddr),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .fsm_state(fsm_state)
    );

    // RAM with two registered read stages
    assign mem_rdata = rd2;
    always @(posedge clk) begin
        if (mem_write) ram[mem_waddr] <= mem_wdata;
        rd1 <= ram[mem_raddr];
        rd2 <= rd1;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (mem_write) begin
            wr_q.push_back({mem_waddr, mem_wdata});
            run = run + 1;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if ((fsm_state == GO1 || fsm_state == GO2) && cpu_reset) go_hi = go_hi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic get_tx(input string tag, input logic [7:0] exp);
        int n = 0;
        while (tx_q.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (tx_q.size() == 0) chk({tag, "_no_tx"}, 32'(tx_q.size()), 32'd1);
        else                  chk(tag, 32'(tx_q.pop_front()), 32'(exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        int t0, n;
        logic [7:0] d0;
        logic stable;
        for (int i = 0; i < 512; i++) ram[i] = 8'h00;
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
        cpu_halted = 1'b0; cpu_raddr = '0; cpu_waddr = '0; cpu_wdata = 8'h00; cpu_write = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_cpu_halt", 32'(cpu_halt), 32'd0);
        chk("rst_start", 32'(start_address), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'(IDLE));

        // W 00 10 03 AA BB CC
        wr_q.delete(); max_run = 0;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        get_tx("w1_ack", 8'h06);
        chk("w1_count", 32'(wr_q.size()), 32'd3);
        chk("w1_wr0", 32'(wr_q[0]), 32'({9'h010, 8'hAA}));
        chk("w1_wr1", 32'(wr_q[1]), 32'({9'h011, 8'hBB}));
        chk("w1_wr2", 32'(wr_q[2]), 32'({9'h012, 8'hCC}));
        chk("w1_strobe_width", 32'(max_run), 32'd1);
        chk("w1_state", 32'(fsm_state), 32'(IDLE));

        // R 00 10 03 with a 5-cycle tx stall on the second data byte
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03);
        get_tx("r1_d0", 8'hAA);
        tx_ready = 1'b0;
        n = 0;
        while (!tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        d0 = tx_data;
        stable = tx_valid;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(tx_valid && tx_data == d0)) stable = 1'b0;
        end
        chk("r1_stall_stable", 32'(stable), 32'd1);
        chk("r1_stall_data", 32'(d0), 32'hBB);
        tx_ready = 1'b1;
        get_tx("r1_d1", 8'hBB);
        get_tx("r1_d2", 8'hCC);
        get_tx("r1_ack", 8'h06);

        // W 01 FF 02 11 22: address wraps past 0x1FF
        wr_q.delete(); max_run = 0;
        send_byte(8'h57); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        get_tx("w2_ack", 8'h06);
        chk("w2_count", 32'(wr_q.size()), 32'd2);
        chk("w2_wr0", 32'(wr_q[0]), 32'({9'h1FF, 8'h11}));
        chk("w2_wr1", 32'(wr_q[1]), 32'({9'h000, 8'h22}));

        // G 00 20
        go_hi = 0;
        send_byte(8'h47); send_byte(8'h00); send_byte(8'h20);
        get_tx("g_ack", 8'h06);
        chk("g_start", 32'(start_address), 32'h020);
        chk("g_reset_hold", 32'(go_hi), 32'd2);
        chk("g_cpu_reset", 32'(cpu_reset), 32'd0);
        @(negedge clk);
        cpu_raddr = 9'h055; cpu_waddr = 9'h066; cpu_wdata = 8'h77; cpu_write = 1'b1;
        #1;
        chk("pt_raddr", 32'(mem_raddr), 32'h055);
        chk("pt_waddr", 32'(mem_waddr), 32'h066);
        chk("pt_wdata", 32'(mem_wdata), 32'h77);
        chk("pt_write", 32'(mem_write), 32'd1);
        @(negedge clk);
        cpu_write = 1'b0;
        @(negedge clk);

        // core running: W is NAKed with no writes; then H, S
        wr_q.delete();
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h55);
        get_tx("run_w_nak", 8'h15);
        chk("run_no_write", 32'(wr_q.size()), 32'd0);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10); send_byte(8'h01);
        get_tx("run_r_nak", 8'h15);
        send_byte(8'h48);
        get_tx("h_ack", 8'h06);
        chk("h_cpu_halt", 32'(cpu_halt), 32'd1);
        cpu_halted = 1'b1;
        send_byte(8'h53);
        get_tx("s_status", 8'h01);

        // mid-frame timeout, then an unknown command
        wr_q.delete();
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
        t0 = cyc;
        get_tx("to_nak", 8'h15);
        chk("to_window", 32'((cyc - t0) >= TO && (cyc - t0) <= TO + 6), 32'd1);
        chk("to_state", 32'(fsm_state), 32'(IDLE));
        chk("to_no_write", 32'(wr_q.size()), 32'd0);
        send_byte(8'h7E);
        get_tx("unknown_nak", 8'h15);

        // reset mid-frame keeps the partial write
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h30); send_byte(8'h02); send_byte(8'h99);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mr_cpu_halt", 32'(cpu_halt), 32'd0);
        chk("mr_start", 32'(start_address), 32'd0);
        chk("mr_state", 32'(fsm_state), 32'(IDLE));
        chk("mr_partial", 32'(ram[9'h030]), 32'h99);
        chk("mr_tx_valid", 32'(tx_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
